// File: rtl/uart_pic_loader_pkg.sv
// Shared types and elaboration helpers for the UART picture loader.
package uart_pic_loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        LD_IDLE,
        LD_LOAD
    } ld_state_t;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Bits needed to count 0..n-1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_pic_loader_if.sv
// Serial input plus byte, pixel-write and frame-status outputs of the loader.
interface uart_pic_loader_if #(
    parameter int BPP    = 3,
    parameter int ADDR_W = 17
);
    logic                 din;
    logic [7:0]           dout;
    logic                 byte_valid;
    logic                 frame_err;
    logic [8*BPP-1:0]     pix_out;
    logic [ADDR_W-1:0]    addr;
    logic                 wr_ram;
    logic                 pic_download;
    logic                 pic_done;

    modport master (
        input  din,
        output dout, byte_valid, frame_err, pix_out, addr, wr_ram, pic_download, pic_done
    );

    modport slave (
        output din,
        input  dout, byte_valid, frame_err, pix_out, addr, wr_ram, pic_download, pic_done
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, stop-bit check.
module uart_rx_byte
    import uart_pic_loader_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] dout,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int CW   = cnt_w(DIV);
    localparam int HALF = DIV / 2;

    logic      sync1_q, sync2_q, prev_q;
    rx_state_t st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d, dout_q, dout_d;
    logic       bv_q, bv_d, fe_q, fe_d;

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q + CW'(1);
        bit_d  = bit_q;
        sh_d   = sh_q;
        dout_d = dout_q;
        bv_d   = 1'b0;
        fe_d   = 1'b0;
        case (st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) st_d = RX_START;
            end
            RX_START: if (cnt_q == CW'(HALF - 1)) begin
                cnt_d = '0;
                bit_d = 3'd0;
                st_d  = sync2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == CW'(DIV - 1)) begin
                cnt_d = '0;
                sh_d  = {sync2_q, sh_q[7:1]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) st_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == CW'(DIV - 1)) begin
                cnt_d = '0;
                st_d  = RX_IDLE;
                if (sync2_q) begin
                    dout_d = sh_q;
                    bv_d   = 1'b1;
                end else begin
                    fe_d = 1'b1;
                end
            end
            default: st_d = RX_IDLE;
        endcase
    end

    // Synchronizer resets to the idle-high level so release never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            st_q    <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            sh_q    <= 8'd0;
            dout_q  <= 8'd0;
            bv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            bv_q    <= bv_d;
            fe_q    <= fe_d;
        end
    end

    assign dout       = dout_q;
    assign byte_valid = bv_q;
    assign frame_err  = fe_q;
endmodule

// File: rtl/uart_pic_loader.sv
// Packs received UART bytes into pixels and streams them to RAM, one frame at a time.
module uart_pic_loader
    import uart_pic_loader_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int BAUD          = 115200,
    parameter int BPP           = 3,
    parameter int ADDR_W        = 17,
    parameter int PIX_COUNT     = 76800,
    parameter int TIMEOUT_BYTES = 16
) (
    input  logic clk,
    input  logic rst,
    uart_pic_loader_if.master bus
);
    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int TMO = TIMEOUT_BYTES * 10 * DIV;
    localparam int TW  = cnt_w(TMO);
    localparam int PW  = 8 * BPP;
    localparam int BW  = cnt_w(BPP);

    logic [7:0] rx_byte;
    logic       rx_bv, rx_fe;

    uart_rx_byte #(.DIV(DIV)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .din        (bus.din),
        .dout       (rx_byte),
        .byte_valid (rx_bv),
        .frame_err  (rx_fe)
    );

    ld_state_t         ld_q, ld_d;
    logic [BW-1:0]     bidx_q, bidx_d;
    logic [PW-1:0]     acc_q, acc_d, pix_q, pix_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              wr_q, wr_d, done_q, done_d;

    always_comb begin
        ld_d   = ld_q;
        bidx_d = bidx_q;
        acc_d  = acc_q;
        pix_d  = pix_q;
        addr_d = addr_q;
        tmo_d  = tmo_q;
        wr_d   = 1'b0;
        done_d = 1'b0;
        // Address advances the cycle after the strobe; the last pixel closes the frame.
        if (wr_q) begin
            if (addr_q == ADDR_W'(PIX_COUNT - 1)) begin
                addr_d = '0;
                ld_d   = LD_IDLE;
                done_d = 1'b1;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
        if (rx_bv) begin
            ld_d  = LD_LOAD;
            tmo_d = '0;
            acc_d = (acc_q << 8) | PW'(rx_byte);
            if (bidx_q == BW'(BPP - 1)) begin
                bidx_d = '0;
                pix_d  = acc_d;
                wr_d   = 1'b1;
            end else begin
                bidx_d = bidx_q + BW'(1);
            end
        end else if (ld_q == LD_LOAD) begin
            if (tmo_q == TW'(TMO - 1)) begin
                ld_d   = LD_IDLE;
                addr_d = '0;
                bidx_d = '0;
                acc_d  = '0;
                tmo_d  = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_q   <= LD_IDLE;
            bidx_q <= '0;
            acc_q  <= '0;
            pix_q  <= '0;
            addr_q <= '0;
            tmo_q  <= '0;
            wr_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            ld_q   <= ld_d;
            bidx_q <= bidx_d;
            acc_q  <= acc_d;
            pix_q  <= pix_d;
            addr_q <= addr_d;
            tmo_q  <= tmo_d;
            wr_q   <= wr_d;
            done_q <= done_d;
        end
    end

    assign bus.dout         = rx_byte;
    assign bus.byte_valid   = rx_bv;
    assign bus.frame_err    = rx_fe;
    assign bus.pix_out      = pix_q;
    assign bus.addr         = addr_q;
    assign bus.wr_ram       = wr_q;
    assign bus.pic_done     = done_q;
    // The first byte of a frame raises the flag in the same cycle it arrives.
    assign bus.pic_download = (ld_q == LD_LOAD) || rx_bv;
endmodule

// File: tb/tb_uart_pic_loader.sv
// Bench for uart_pic_loader: byte vector table, directed frame corner cases, random frames.
module tb_uart_pic_loader;
    localparam int DIV    = 10;
    localparam int BPP    = 3;
    localparam int ADDR_W = 2;
    localparam int PIX    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_pic_loader_if #(.BPP(BPP), .ADDR_W(ADDR_W)) bus ();

    uart_pic_loader #(
        .CLK_HZ(1_000_000), .BAUD(100_000), .BPP(BPP), .ADDR_W(ADDR_W),
        .PIX_COUNT(PIX), .TIMEOUT_BYTES(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0]  a;
        logic [23:0] p;
    } wr_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_bv;
        int         exp_fe;
        logic [7:0] exp_dout;
        logic       exp_dl;
    } vec_t;

    int tests = 0, fails = 0, cyc = 0;
    logic [7:0] bv_log[$];
    wr_t        wr_log[$];
    logic [7:0] exp_b[$];
    int fe_n = 0, done_n = 0, last_wr_cyc = -10;
    logic prev_bv = 1'b0, prev_fe = 1'b0, prev_dl = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Event monitor: logs pulses and checks pulse width / completion timing.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (bus.byte_valid) begin
            bv_log.push_back(bus.dout);
            chk("bv_one_cycle", 64'(prev_bv), 0);
        end
        if (bus.frame_err) begin
            fe_n++;
            chk("fe_one_cycle", 64'(prev_fe), 0);
        end
        if (bus.wr_ram) begin
            wr_log.push_back({bus.addr, bus.pix_out});
            last_wr_cyc = cyc;
        end
        if (bus.pic_done) begin
            done_n++;
            chk("done_after_wr", 64'(cyc - last_wr_cyc), 1);
            chk("done_dl_fall", {62'd0, prev_dl, bus.pic_download}, 2);
            chk("done_addr0", 64'(bus.addr), 0);
        end
        prev_bv = bus.byte_valid;
        prev_fe = bus.frame_err;
        prev_dl = bus.pic_download;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic v, input int n);
        bus.din = v;
        idle(n);
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input int stop_len, input int tail);
        drive(1'b0, DIV);
        for (int i = 0; i < 8; i++) drive(d[i], DIV);
        drive(stop, stop_len);
        if (tail > 0) drive(1'b1, tail);
    endtask

    // Compact framing: stop level held only past its sample point, keeping byte gaps short.
    task automatic send_good(input logic [7:0] d); send(d, 1'b1, DIV, 0); exp_b.push_back(d); endtask
    task automatic send_cmp(input logic [7:0] d);  send(d, 1'b1, 7, 0);   exp_b.push_back(d); endtask
    task automatic send_bad(input logic [7:0] d);  send(d, 1'b0, 7, 1);   endtask

    task automatic clear();
        bv_log.delete();
        wr_log.delete();
        exp_b.delete();
        fe_n = 0;
        done_n = 0;
        last_wr_cyc = -10;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.din = 1'b1;
        idle(4);
        rst = 1'b0;
        idle(4);
        clear();
    endtask

    function automatic logic [63:0] all_outs();
        return {25'd0, bus.dout, bus.pix_out, bus.addr, bus.byte_valid, bus.frame_err,
                bus.wr_ram, bus.pic_download, bus.pic_done};
    endfunction

    task automatic check_frame(input string nm);
        chk({nm, "_nwr"}, 64'(wr_log.size()), PIX);
        chk({nm, "_nbv"}, 64'(bv_log.size()), 64'(exp_b.size()));
        for (int i = 0; i < PIX && i < wr_log.size() && 3 * i + 2 < exp_b.size(); i++) begin
            chk($sformatf("%s_addr%0d", nm, i), 64'(wr_log[i].a), 64'(i));
            chk($sformatf("%s_pix%0d", nm, i), 64'(wr_log[i].p),
                {40'd0, exp_b[3*i], exp_b[3*i+1], exp_b[3*i+2]});
        end
        chk({nm, "_done"}, 64'(done_n), 1);
        chk({nm, "_addr_end"}, 64'(bus.addr), 0);
        chk({nm, "_dl_end"}, 64'(bus.pic_download), 0);
    endtask

    vec_t vecs[6];

    initial begin
        logic [7:0] rb;
        int nbad;
        bus.din = 1'b1;
        vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5, 1'b1};
        vecs[1] = '{8'h3C, 1'b1, 1, 0, 8'h3C, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00, 1'b1};
        vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF, 1'b1};
        vecs[4] = '{8'h11, 1'b0, 0, 1, 8'h00, 1'b0};
        vecs[5] = '{8'h80, 1'b0, 0, 1, 8'h00, 1'b0};
        @(negedge clk);
        do_reset();
        chk("reset_outs", all_outs(), 0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            send(vecs[v].data, vecs[v].stop, DIV, vecs[v].stop ? 0 : 3);
            idle(5);
            chk($sformatf("vec%0d_nbv", v), 64'(bv_log.size()), 64'(vecs[v].exp_bv));
            chk($sformatf("vec%0d_nfe", v), 64'(fe_n), 64'(vecs[v].exp_fe));
            chk($sformatf("vec%0d_dout", v), 64'(bus.dout), 64'(vecs[v].exp_dout));
            chk($sformatf("vec%0d_dl", v), 64'(bus.pic_download), 64'(vecs[v].exp_dl));
            if (vecs[v].exp_bv == 1 && bv_log.size() == 1)
                chk($sformatf("vec%0d_bvdata", v), 64'(bv_log[0]), 64'(vecs[v].data));
        end

        // Short low glitch must be rejected as a false start.
        do_reset();
        drive(1'b0, 3);
        drive(1'b1, 30);
        chk("glitch_nbv", 64'(bv_log.size()), 0);
        chk("glitch_nfe", 64'(fe_n), 0);

        do_reset();
        for (int i = 0; i < 12; i++) send_good(8'(i));
        idle(5);
        check_frame("frame_seq");
        chk("pix_hold", 64'(bus.pix_out), 64'h090A0B);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i == 5) send_bad(8'h11);
            send_cmp(8'(i));
        end
        idle(5);
        chk("ferr_count", 64'(fe_n), 1);
        check_frame("frame_ferr");

        // Idle timeout mid-frame.
        do_reset();
        for (int i = 0; i < 4; i++) send_good(8'(i));
        idle(150);
        chk("tmo_dl_still", 64'(bus.pic_download), 1);
        idle(100);
        chk("tmo_nwr", 64'(wr_log.size()), 1);
        if (wr_log.size() > 0) chk("tmo_wr0", 64'(wr_log[0]), {38'd0, 2'd0, 24'h000102});
        chk("tmo_done", 64'(done_n), 0);
        chk("tmo_dl", 64'(bus.pic_download), 0);
        chk("tmo_addr", 64'(bus.addr), 0);
        clear();
        for (int i = 0; i < 12; i++) send_good(8'(8'h20 + i));
        idle(5);
        check_frame("frame_after_tmo");

        // Reset in the middle of a bit of the second pixel.
        do_reset();
        for (int i = 0; i < 4; i++) send_good(8'(i));
        drive(1'b0, DIV);
        drive(1'b1, DIV);
        drive(1'b0, 5);
        rst = 1'b1;
        bus.din = 1'b1;
        idle(1);
        chk("midrst_outs", all_outs(), 0);
        idle(3);
        rst = 1'b0;
        idle(20);
        chk("postrst_outs", all_outs(), 0);
        clear();
        for (int i = 0; i < 12; i++) send_good(8'(8'h40 + i));
        idle(5);
        check_frame("frame_after_rst");

        // Random frames with occasional bad-stop bytes, back to back without reset.
        for (int f = 0; f < 3; f++) begin
            clear();
            nbad = 0;
            for (int k = 0; k < 12; k++) begin
                rb = 8'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    send_bad(8'($urandom));
                    nbad++;
                end else begin
                    idle($urandom_range(0, 40));
                end
                send_cmp(rb);
            end
            idle(5);
            chk($sformatf("rnd%0d_nfe", f), 64'(fe_n), 64'(nbad));
            check_frame($sformatf("rnd%0d", f));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
